// File: rtl/tcm_exec_unit_if.sv
// Instruction handshake bus between the fetch side and the two-counter machine's execute stage.
interface tcm_exec_unit_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              instr_valid;
  logic              instr_ready;
  logic [1:0]        opcode;
  logic              reg_sel;
  logic [ADDR_W-1:0] jmp_target;

  // Instruction source.
  modport master (
    output instr_valid,
    output opcode,
    output reg_sel,
    output jmp_target,
    input  instr_ready
  );

  // Execute unit.
  modport slave (
    input  instr_valid,
    input  opcode,
    input  reg_sel,
    input  jmp_target,
    output instr_ready
  );
endinterface

// File: rtl/tcm_exec_unit.sv
// Execute stage of the two-counter machine (counters A=0, B=1).
// Accepts one instruction per three cycles, drives the counter-file write port,
// resolves JZ branches and keeps the program counter.
// Optional macro TCM_SAT_EN: INC saturates at 255 and pulses ovf instead of wrapping.
module tcm_exec_unit #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              reset,
  tcm_exec_unit_if.slave    instr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              rf_WE,
  output logic              rf_dest,
  output logic [7:0]        rf_WB,
  output logic              rf_srcA,
  output logic              rf_srcB,
  input  logic [7:0]        rf_R1,
  input  logic [7:0]        rf_R2,
  output logic              zero_a,
  output logic              zero_b
`ifdef TCM_SAT_EN
  ,
  output logic              ovf
`endif
);

  localparam logic [1:0] OpInc  = 2'b00;
  localparam logic [1:0] OpDec  = 2'b01;
  localparam logic [1:0] OpJz   = 2'b10;
  localparam logic [1:0] OpHalt = 2'b11;

  typedef enum logic [1:0] {StIdle, StExec, StCommit, StHalt} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic              halted_q;
  logic              sel_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] tgt_q;
  logic              taken_q;
  logic              accept;
  logic              r1_zero;
  logic              r1_max;

  assign accept  = instr.instr_valid & instr.instr_ready;
  assign r1_zero = (rf_R1 == 8'd0);
  assign r1_max  = (rf_R1 == 8'hFF);

  // Ready only in IDLE, and forced low while reset is held.
  assign instr.instr_ready = (state_q == StIdle) & reset;

  assign pc      = pc_q;
  assign halted  = halted_q;
  assign rf_srcA = sel_q;
  assign rf_srcB = ~sel_q;

  // R1 always carries the operand counter, so map back to A/B through sel.
  assign zero_a = sel_q ? (rf_R2 == 8'd0) : r1_zero;
  assign zero_b = sel_q ? r1_zero : (rf_R2 == 8'd0);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = (instr.opcode == OpHalt) ? StHalt : StExec;
      StExec:   state_d = StCommit;
      StCommit: state_d = StIdle;
      StHalt:   state_d = StHalt;
      default:  state_d = StIdle;
    endcase
  end

  // Write port decode: gated by the EXEC state register, so an async reset kills it at once.
  always_comb begin
    rf_WE   = 1'b0;
    rf_WB   = 8'd0;
    rf_dest = sel_q;
    if (state_q == StExec) begin
      unique case (op_q)
        OpInc: begin
`ifdef TCM_SAT_EN
          rf_WE = ~r1_max;
`else
          rf_WE = 1'b1;
`endif
          rf_WB = rf_R1 + 8'd1;
        end
        OpDec: begin
          rf_WE = ~r1_zero;
          rf_WB = rf_R1 - 8'd1;
        end
        default: begin
          rf_WE = 1'b0;
          rf_WB = 8'd0;
        end
      endcase
    end
  end

  // State register and latched instruction fields.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      halted_q <= 1'b0;
      sel_q    <= 1'b0;
      op_q     <= OpInc;
      tgt_q    <= '0;
      taken_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel_q <= instr.reg_sel;
        op_q  <= instr.opcode;
        tgt_q <= instr.jmp_target;
        if (instr.opcode == OpHalt) halted_q <= 1'b1;
      end
      if (state_q == StExec) taken_q <= (op_q == OpJz) & r1_zero;
      if (state_q == StCommit) pc_q <= taken_q ? tgt_q : pc_q + ADDR_W'(1);
    end
  end

`ifdef TCM_SAT_EN
  logic ovf_q;

  // Saturation flag: set at the end of EXEC so it covers exactly the COMMIT cycle.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= (state_q == StExec) & (op_q == OpInc) & r1_max;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_tcm_exec_unit.sv
// Self-checking bench for tcm_exec_unit with a behavioural two-counter file and a write scoreboard.
module tb_tcm_exec_unit;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  tcm_exec_unit_if #(.ADDR_W(4)) bus ();

  logic [3:0] pc;
  logic       halted, rf_WE, rf_dest, rf_srcA, rf_srcB, zero_a, zero_b;
  logic [7:0] rf_WB, rf_R1, rf_R2;
`ifdef TCM_SAT_EN
  logic ovf;
  int   ovf_cnt = 0;
`endif

  tcm_exec_unit #(.ADDR_W(4)) dut (
    .CLK     (CLK),
    .reset   (reset),
    .instr   (bus.slave),
    .pc      (pc),
    .halted  (halted),
    .rf_WE   (rf_WE),
    .rf_dest (rf_dest),
    .rf_WB   (rf_WB),
    .rf_srcA (rf_srcA),
    .rf_srcB (rf_srcB),
    .rf_R1   (rf_R1),
    .rf_R2   (rf_R2),
    .zero_a  (zero_a),
    .zero_b  (zero_b)
`ifdef TCM_SAT_EN
    ,
    .ovf     (ovf)
`endif
  );

  localparam logic [1:0] INC = 2'b00, DEC = 2'b01, JZ = 2'b10, HALT = 2'b11;

  // Counter file model: combinational reads, write on rising edge, bench preload port.
  logic [7:0] cnt [2];
  logic       pl_en = 1'b0;
  logic       pl_idx = 1'b0;
  logic [7:0] pl_val = 8'd0;
  assign rf_R1 = cnt[rf_srcA];
  assign rf_R2 = cnt[rf_srcB];
  always @(posedge CLK) begin
    if (rf_WE === 1'b1) cnt[rf_dest] <= rf_WB;
    else if (pl_en)     cnt[pl_idx] <= pl_val;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       dest;
    logic [7:0] data;
  } wr_t;
  wr_t wexp_q[$];

  // Scoreboard: every write-enable cycle must match the oldest expected write.
  always @(negedge CLK) begin
    if (rf_WE === 1'b1) begin
      checks++;
      if (wexp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got dest=%0d data=%0d, required no write", rf_dest, rf_WB);
      end else begin
        wr_t e;
        e = wexp_q.pop_front();
        if (rf_dest !== e.dest || rf_WB !== e.data) begin
          errors++;
          $display("FAIL write: got dest=%0d data=%0d, required dest=%0d data=%0d",
                   rf_dest, rf_WB, e.dest, e.data);
        end
      end
    end
`ifdef TCM_SAT_EN
    if (ovf === 1'b1) ovf_cnt++;
`endif
  end

  // Called at a falling edge; returns at a falling edge.
  task automatic preload(input logic idx, input logic [7:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge CLK);
    #1 pl_en = 1'b0;
    @(negedge CLK);
  endtask

  task automatic push_wr(input logic dest, input logic [7:0] data);
    wr_t e;
    e.dest = dest; e.data = data;
    wexp_q.push_back(e);
  endtask

  // Drives one instruction, waits for acceptance, then follows it back to IDLE.
  task automatic issue(input logic [1:0] op, input logic rs, input logic [3:0] tgt,
                       output int acc);
    bit got = 0;
    bus.instr_valid = 1'b1; bus.opcode = op; bus.reg_sel = rs; bus.jmp_target = tgt;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_ready === 1'b1) begin
        @(posedge CLK);
        got = 1;
        break;
      end
      @(negedge CLK);
    end
    #1;
    acc = cyc;
    bus.instr_valid = 1'b0;
    bus.opcode = 2'($urandom_range(0, 3));
    bus.reg_sel = 1'($urandom_range(0, 1));
    bus.jmp_target = 4'($urandom_range(0, 15));
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout: got no accept in 20 cycles, required accept op=%0d", op);
      @(negedge CLK);
    end else begin
      repeat (3) @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.instr_valid = 1'b0; bus.opcode = INC; bus.reg_sel = 1'b0; bus.jmp_target = 4'd0;
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.instr_ready !== 1'b0) begin errors++;
      $display("FAIL reset_ready: got %b required 0", bus.instr_ready); end
    checks++; if (rf_WE !== 1'b0) begin errors++;
      $display("FAIL reset_we: got %b required 0", rf_WE); end
    checks++; if (pc !== 4'd0) begin errors++;
      $display("FAIL reset_pc: got %0d required 0", pc); end
    checks++; if (halted !== 1'b0) begin errors++;
      $display("FAIL reset_halted: got %b required 0", halted); end
    checks++; if (rf_WB !== 8'd0 || rf_dest !== 1'b0) begin errors++;
      $display("FAIL reset_wb: got wb=%0d dest=%b required 0/0", rf_WB, rf_dest); end
    repeat (2) @(posedge CLK);
    @(negedge CLK) reset = 1'b1;
    #1;
    checks++; if (bus.instr_ready !== 1'b1) begin errors++;
      $display("FAIL reset_release_ready: got %b required 1", bus.instr_ready); end
    @(negedge CLK);
  endtask

  task automatic test_inc();
    int acc, prev;
    preload(1'b0, 8'd0);
    preload(1'b1, 8'd0);
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      push_wr(1'b0, 8'(i + 1));
      issue(INC, 1'b0, 4'd0, acc);
      checks++; if (pc !== 4'(i + 1)) begin errors++;
        $display("FAIL inc_pc: got %0d required %0d", pc, i + 1); end
      if (i > 0) begin
        checks++; if (acc - prev != 3) begin errors++;
          $display("FAIL issue_spacing: got %0d cycles required 3", acc - prev); end
      end
      prev = acc;
    end
    checks++; if (cnt[0] !== 8'd3 || wexp_q.size() != 0) begin errors++;
      $display("FAIL inc_value: got A=%0d pending=%0d required A=3 pending=0",
               cnt[0], wexp_q.size()); end
  endtask

  task automatic test_dec();
    int acc;
    preload(1'b0, 8'd0);
    issue(DEC, 1'b0, 4'd0, acc);
    checks++; if (pc !== 4'd4 || cnt[0] !== 8'd0) begin errors++;
      $display("FAIL dec_zero: got pc=%0d A=%0d required pc=4 A=0", pc, cnt[0]); end
    preload(1'b0, 8'd2);
    push_wr(1'b0, 8'd1);
    issue(DEC, 1'b0, 4'd0, acc);
    checks++; if (pc !== 4'd5 || cnt[0] !== 8'd1 || wexp_q.size() != 0) begin errors++;
      $display("FAIL dec_two: got pc=%0d A=%0d required pc=5 A=1", pc, cnt[0]); end
  endtask

  task automatic test_jz();
    int acc;
    preload(1'b1, 8'd0);
    issue(JZ, 1'b1, 4'd9, acc);
    checks++; if (pc !== 4'd9) begin errors++;
      $display("FAIL jz_taken: got pc=%0d required 9", pc); end
    issue(JZ, 1'b1, 4'd4, acc);
    checks++; if (pc !== 4'd4) begin errors++;
      $display("FAIL jz_taken2: got pc=%0d required 4", pc); end
    preload(1'b1, 8'd5);
    issue(JZ, 1'b1, 4'd9, acc);
    checks++; if (pc !== 4'd5 || cnt[1] !== 8'd5) begin errors++;
      $display("FAIL jz_not_taken: got pc=%0d B=%0d required pc=5 B=5", pc, cnt[1]); end
    checks++; if (zero_a !== (cnt[0] == 8'd0) || zero_b !== (cnt[1] == 8'd0)) begin errors++;
      $display("FAIL zero_flags: got a=%b b=%b required a=%b b=%b",
               zero_a, zero_b, cnt[0] == 8'd0, cnt[1] == 8'd0); end
  endtask

  task automatic test_wrap();
    int acc;
    preload(1'b0, 8'd255);
`ifdef TCM_SAT_EN
    ovf_cnt = 0;
    issue(INC, 1'b0, 4'd0, acc);
    checks++; if (cnt[0] !== 8'd255 || ovf_cnt != 1) begin errors++;
      $display("FAIL inc_sat: got A=%0d ovf_cycles=%0d required A=255 ovf_cycles=1",
               cnt[0], ovf_cnt); end
`else
    push_wr(1'b0, 8'd0);
    issue(INC, 1'b0, 4'd0, acc);
    checks++; if (cnt[0] !== 8'd0) begin errors++;
      $display("FAIL inc_wrap: got A=%0d required 0", cnt[0]); end
`endif
    checks++; if (pc !== 4'd6 || wexp_q.size() != 0) begin errors++;
      $display("FAIL wrap_pc: got pc=%0d required 6", pc); end
  endtask

  task automatic test_halt();
    int acc;
    bit seen_ready = 0;
    issue(HALT, 1'b0, 4'd3, acc);
    checks++; if (halted !== 1'b1 || pc !== 4'd6 || bus.instr_ready !== 1'b0) begin errors++;
      $display("FAIL halt: got halted=%b pc=%0d ready=%b required 1/6/0",
               halted, pc, bus.instr_ready); end
    for (int i = 0; i < 10; i++) begin
      bus.instr_valid = 1'b1;
      bus.opcode = 2'($urandom_range(0, 2));
      bus.reg_sel = 1'($urandom_range(0, 1));
      @(negedge CLK);
      if (bus.instr_ready !== 1'b0) seen_ready = 1;
    end
    bus.instr_valid = 1'b0;
    checks++; if (seen_ready || halted !== 1'b1 || pc !== 4'd6) begin errors++;
      $display("FAIL halt_sticky: got ready_seen=%b halted=%b pc=%0d required 0/1/6",
               seen_ready, halted, pc); end
  endtask

  task automatic test_reset_exec();
    @(negedge CLK) reset = 1'b0;
    @(negedge CLK) reset = 1'b1;
    @(negedge CLK);
    checks++; if (halted !== 1'b0 || pc !== 4'd0) begin errors++;
      $display("FAIL unhalt: got halted=%b pc=%0d required 0/0", halted, pc); end
    preload(1'b0, 8'd7);
    bus.instr_valid = 1'b1; bus.opcode = INC; bus.reg_sel = 1'b0;
    @(posedge CLK);
    #1 bus.instr_valid = 1'b0;
    checks++; if (rf_WE !== 1'b1) begin errors++;
      $display("FAIL exec_we: got %b required 1", rf_WE); end
    #1 reset = 1'b0;
    #1;
    checks++; if (rf_WE !== 1'b0 || bus.instr_ready !== 1'b0 || pc !== 4'd0) begin errors++;
      $display("FAIL reset_mid_exec: got we=%b ready=%b pc=%0d required 0/0/0",
               rf_WE, bus.instr_ready, pc); end
    @(posedge CLK);
    #1;
    checks++; if (cnt[0] !== 8'd7) begin errors++;
      $display("FAIL reset_no_write: got A=%0d required 7", cnt[0]); end
    @(negedge CLK) reset = 1'b1;
    #1;
    checks++; if (bus.instr_ready !== 1'b1 || pc !== 4'd0) begin errors++;
      $display("FAIL reset_idle: got ready=%b pc=%0d required 1/0", bus.instr_ready, pc); end
    @(negedge CLK);
  endtask

  task automatic test_pc_wrap();
    int acc;
    preload(1'b1, 8'd0);
    issue(JZ, 1'b1, 4'd15, acc);
    checks++; if (pc !== 4'd15) begin errors++;
      $display("FAIL jz_15: got pc=%0d required 15", pc); end
    push_wr(1'b1, 8'd1);
    issue(INC, 1'b1, 4'd0, acc);
    checks++; if (pc !== 4'd0 || cnt[1] !== 8'd1 || wexp_q.size() != 0) begin errors++;
      $display("FAIL pc_wrap: got pc=%0d B=%0d required pc=0 B=1", pc, cnt[1]); end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_dec();
    test_jz();
    test_wrap();
    test_halt();
    test_reset_exec();
    test_pc_wrap();
    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
